// File: rtl/decode_stage.sv
// RV32I ID stage: control/immediate decode, 32x32 register file, ID/EX pipeline register.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle writeback onto the register reads.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic            IllegalE
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmJ} immSel_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rdD;
  logic            regWriteD, memWriteD, jumpD, branchD, aluSrcD, illegalD;
  logic [1:0]      resultSrcD;
  logic [2:0]      aluCtlD, aluOpD;
  logic            aluBad;
  immSel_t         immSel;
  logic [XLEN-1:0] immExtD, rd1D, rd2D;
  logic [XLEN-1:0] regs [NREGS];

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rdD    = InstrD[11:7];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // Shared ALU table; only R-type may select sub via funct7[5].
  always_comb begin
    aluOpD = AluAdd;
    aluBad = 1'b0;
    case (funct3)
      3'b000:  aluOpD = (opcode == OpRType && InstrD[30]) ? AluSub : AluAdd;
      3'b111:  aluOpD = AluAnd;
      3'b110:  aluOpD = AluOr;
      3'b010:  aluOpD = AluSlt;
      default: aluBad = 1'b1;
    endcase
  end

  always_comb begin
    regWriteD  = 1'b0;
    memWriteD  = 1'b0;
    jumpD      = 1'b0;
    branchD    = 1'b0;
    aluSrcD    = 1'b0;
    resultSrcD = 2'b00;
    aluCtlD    = AluAdd;
    illegalD   = 1'b0;
    immSel     = ImmNone;
    case (opcode)
      OpLoad: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 2'b01;
        immSel     = ImmI;
      end
      OpStore: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immSel    = ImmS;
      end
      OpRType: begin
        regWriteD = 1'b1;
        aluCtlD   = aluOpD;
        illegalD  = aluBad;
      end
      OpIAlu: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immSel    = ImmI;
        aluCtlD   = aluOpD;
        illegalD  = aluBad;
      end
      OpBeq: begin
        branchD = 1'b1;
        aluCtlD = AluSub;
        immSel  = ImmB;
      end
      OpJal: begin
        regWriteD  = 1'b1;
        jumpD      = 1'b1;
        resultSrcD = 2'b10;
        immSel     = ImmJ;
      end
      // An all-zero word is a fetch bubble, not an illegal instruction.
      default: illegalD = (InstrD != 32'h0);
    endcase
  end

  always_comb begin
    immExtD = '0;
    case (immSel)
      ImmI:    immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      ImmS:    immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      ImmB:    immExtD = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      ImmJ:    immExtD = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21],
                          1'b0};
      default: immExtD = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (RegWriteW && RdW != 5'd0) begin
      regs[RdW] <= ResultW;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  always_comb begin
    rd1D = (Rs1D == 5'd0) ? '0 : regs[Rs1D];
    rd2D = (Rs2D == 5'd0) ? '0 : regs[Rs2D];
    if (RegWriteW && RdW != 5'd0 && RdW == Rs1D) rd1D = ResultW;
    if (RegWriteW && RdW != 5'd0 && RdW == Rs2D) rd2D = ResultW;
  end
`else
  always_comb begin
    rd1D = (Rs1D == 5'd0) ? '0 : regs[Rs1D];
    rd2D = (Rs2D == 5'd0) ? '0 : regs[Rs2D];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || FlushE) begin
      {RD1E, RD2E, ImmExtE, PCE, PCPlus4E} <= '0;
      {Rs1E, Rs2E, RdE}                    <= '0;
      {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE} <= '0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
    end else begin
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      ImmExtE     <= immExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= rdD;
      RegWriteE   <= regWriteD;
      MemWriteE   <= memWriteD;
      JumpE       <= jumpD;
      BranchE     <= branchD;
      ALUSrcE     <= aluSrcD;
      ResultSrcE  <= resultSrcD;
      ALUControlE <= aluCtlD;
      IllegalE    <= illegalD;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, directed corner sequences and a
// randomized run against a behavioural decode/register-file model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        RegWriteW = 1'b0, FlushE = 1'b0;
  logic [4:0]  RdW = '0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .IllegalE(IllegalE)
  );

  // regWrite, memWrite, jump, branch, aluSrc, resultSrc, aluCtl, illegal
  typedef struct packed {
    logic rw, mw, j, b, as;
    logic [1:0] rs;
    logic [2:0] alu;
    logic ill;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    ctrl_t       ctrl;
  } exOut_t;

  typedef struct {
    logic [31:0] instr;
    logic        flush;
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
  } vec_t;

  exOut_t act;
  assign act = {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE,
                JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE};

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] refRegs [32];
  vec_t vecs [12];

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic ctrl_t mk(input logic rw, mw, j, b, as, input logic [1:0] rs,
                               input logic [2:0] alu, input logic ill);
    ctrl_t c;
    c = '{rw: rw, mw: mw, j: j, b: b, as: as, rs: rs, alu: alu, ill: ill};
    return c;
  endfunction

  // Reference decode: immediates rebuilt arithmetically from the field layout.
  function automatic void refDecode(input logic [31:0] ins, output ctrl_t c,
                                    output logic [31:0] imm);
    logic signed [31:0] si;
    logic [31:0] immI, immS, immB, immJ;
    logic [2:0] alu;
    logic bad;
    si   = ins;
    immI = 32'(si >>> 20);
    immS = (32'(si >>> 25) << 5) | 32'(ins[11:7]);
    immB = (32'(si >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
         | (32'(ins[11:8]) << 1);
    immJ = (32'(si >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
         | (32'(ins[30:21]) << 1);
    bad = 1'b0;
    alu = 3'd0;
    if (ins[14:12] == 3'd0)      alu = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
    else if (ins[14:12] == 3'd7) alu = 3'd2;
    else if (ins[14:12] == 3'd6) alu = 3'd3;
    else if (ins[14:12] == 3'd2) alu = 3'd5;
    else                         bad = 1'b1;
    imm = 32'd0;
    c   = '0;
    case (ins[6:0])
      7'h03: begin c = mk(1, 0, 0, 0, 1, 2'b01, 3'd0, 0); imm = immI; end
      7'h23: begin c = mk(0, 1, 0, 0, 1, 2'b00, 3'd0, 0); imm = immS; end
      7'h33: c = mk(1, 0, 0, 0, 0, 2'b00, alu, bad);
      7'h13: begin c = mk(1, 0, 0, 0, 1, 2'b00, alu, bad); imm = immI; end
      7'h63: begin c = mk(0, 0, 0, 1, 0, 2'b00, 3'd1, 0); imm = immB; end
      7'h6F: begin c = mk(1, 0, 1, 0, 0, 2'b10, 3'd0, 0); imm = immJ; end
      default: c.ill = (ins != 32'd0);
    endcase
  endfunction

  function automatic logic [31:0] refRead(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'd0 : refRegs[idx];
`ifdef DECODE_WB_BYPASS_EN
    if (RegWriteW && RdW != 5'd0 && RdW == idx) v = ResultW;
`endif
    return v;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] r;
    logic [6:0] ops [6];
    int k;
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6) begin
      r[6:0] = ops[k];
      if (k == 2) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else if (k == 6) begin
      r = 32'd0;
    end
    return r;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic fl, input logic we,
                       input logic [4:0] rd, input logic [31:0] res);
    @(negedge clk);
    InstrD    = ins;
    FlushE    = fl;
    RegWriteW = we;
    RdW       = rd;
    ResultW   = res;
    PCD       = $urandom;
    PCPlus4D  = PCD + 32'd4;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
    if (RegWriteW && RdW != 5'd0) refRegs[RdW] = ResultW;
  endtask

  initial begin
    exOut_t exp;
    ctrl_t c;
    logic [31:0] imm, val;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;

    vecs[0]  = '{32'h00700293, 0, mk(1,0,0,0,1,2'b00,3'd0,0), 32'd7,        5'd5,  5'd0, 5'd7};
    vecs[1]  = '{32'h00612423, 0, mk(0,1,0,0,1,2'b00,3'd0,0), 32'd8,        5'd8,  5'd2, 5'd6};
    vecs[2]  = '{32'hFE208EE3, 0, mk(0,0,0,1,0,2'b00,3'd1,0), 32'hFFFFFFFC, 5'd29, 5'd1, 5'd2};
    vecs[3]  = '{32'h00000000, 0, mk(0,0,0,0,0,2'b00,3'd0,0), 32'd0,        5'd0,  5'd0, 5'd0};
    vecs[4]  = '{32'h0000007F, 0, mk(0,0,0,0,0,2'b00,3'd0,1), 32'd0,        5'd0,  5'd0, 5'd0};
    vecs[5]  = '{32'h008000EF, 0, mk(1,0,1,0,0,2'b10,3'd0,0), 32'd8,        5'd1,  5'd0, 5'd8};
    vecs[6]  = '{32'hFFC12183, 0, mk(1,0,0,0,1,2'b01,3'd0,0), 32'hFFFFFFFC, 5'd3,  5'd2, 5'd28};
    vecs[7]  = '{32'h403100B3, 0, mk(1,0,0,0,0,2'b00,3'd1,0), 32'd0,        5'd1,  5'd2, 5'd3};
    vecs[8]  = '{32'hFFF0A213, 0, mk(1,0,0,0,1,2'b00,3'd5,0), 32'hFFFFFFFF, 5'd4,  5'd1, 5'd31};
    vecs[9]  = '{32'h00209033, 0, mk(1,0,0,0,0,2'b00,3'd0,1), 32'd0,        5'd0,  5'd1, 5'd2};
    vecs[10] = '{32'h00700293, 1, mk(0,0,0,0,0,2'b00,3'd0,0), 32'd0,        5'd0,  5'd0, 5'd0};
    vecs[11] = '{32'h0FF37313, 0, mk(1,0,0,0,1,2'b00,3'd2,0), 32'h000000FF, 5'd6,  5'd6, 5'd31};

    // Reset state
    #12;
    check("reset_state", 192'(act), 192'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].flush, 1'b0, 5'd0, 32'd0);
      afterEdge();
      check($sformatf("vec%0d_%h", i, vecs[i].instr),
            192'({ctrl_t'({RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                           ALUControlE, IllegalE}), ImmExtE, RdE, Rs1E, Rs2E}),
            192'({vecs[i].ctrl, vecs[i].imm, vecs[i].rd, vecs[i].rs1, vecs[i].rs2}));
    end

    // Same-cycle writeback of x5 while decoding add x7,x5,x0
    drive(32'h000283B3, 0, 1'b1, 5'd5, 32'h12345678);
`ifdef DECODE_WB_BYPASS_EN
    val = 32'h12345678;
`else
    val = 32'd0;
`endif
    afterEdge();
    check("wb_same_cycle_rd1", 192'(RD1E), 192'(val));
    drive(32'h000283B3, 0, 1'b0, 5'd0, 32'd0);
    afterEdge();
    check("wb_next_cycle_rd1", 192'(RD1E), 192'(32'h12345678));

    // Writes to x0 are dropped and never bypassed
    drive(32'h000003B3, 0, 1'b1, 5'd0, 32'hFFFFFFFF);
    afterEdge();
    check("x0_write_same", 192'({RD1E, RD2E}), 192'd0);
    drive(32'h000003B3, 0, 1'b0, 5'd0, 32'd0);
    afterEdge();
    check("x0_write_after", 192'({RD1E, RD2E}), 192'd0);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = genInstr();
      drive(ins, ($urandom_range(0, 7) == 0), 1'($urandom), 5'($urandom), $urandom);
      #1;
      check("rs_comb", 192'({Rs1D, Rs2D}), 192'({ins[19:15], ins[24:20]}));
      refDecode(ins, c, imm);
      if (FlushE) exp = '0;
      else exp = '{rd1: refRead(ins[19:15]), rd2: refRead(ins[24:20]), imm: imm, pc: PCD,
                   pc4: PCPlus4D, rs1: ins[19:15], rs2: ins[24:20], rd: ins[11:7], ctrl: c};
      afterEdge();
      check($sformatf("rand%0d_%h", n, ins), 192'(act), 192'(exp));
    end

    // Load every register, read them back
    for (int i = 1; i < 32; i++) begin
      drive(32'h0, 0, 1'b1, 5'(i), 32'(i) * 32'h01010101 ^ 32'hA5000000);
      afterEdge();
    end
    for (int i = 1; i < 32; i++) begin
      drive({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33}, 0, 1'b0, 5'd0, 32'd0);
      afterEdge();
      check($sformatf("fill_x%0d", i), 192'({RD1E, RD2E}), 192'({refRegs[i], refRegs[i]}));
    end

    // Asynchronous reset mid-cycle with live inputs
    drive(32'h00700293, 0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_now", 192'(act), 192'd0);
    @(posedge clk);
    #1;
    check("async_reset_held", 192'(act), 192'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      drive({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'h33}, 0, 1'b0, 5'd0, 32'd0);
      afterEdge();
      check($sformatf("cleared_x%0d", i), 192'({RD1E, RD2E}), 192'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
ID stage of the 5-stage RV32I pipeline. Consumes the IF/ID outputs (instruction, PC, PC+4) and decodes control signals and the immediate. Reads and writes the 32x32 register file, writing it from the writeback stage. Registers everything into the ID/EX pipeline register, with flush support for the hazard unit.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register file depth (index width 5)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC from IF/ID
PCPlus4D  in  32  PC+4 from IF/ID
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  insert bubble into ID/EX
Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
RD1E, RD2E  out  32  registered operands
ImmExtE  out  32  registered sign-extended immediate
PCE, PCPlus4E  out  32  registered PC, PC+4
Rs1E, Rs2E, RdE  out  5  registered register indices
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1  registered controls
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
IllegalE  out  1  registered illegal-opcode flag

Behaviour:
- Reset (rst=0, asynchronous): all ID/EX outputs 0; all 32 registers cleared to 0. Reset mid-operation takes effect immediately, with no clock edge needed.
- Latency: 1 cycle. Values decoded from InstrD at edge N appear on the *E outputs after edge N.
- Register file:
  - Writes on posedge clk when RegWriteW=1 and RdW!=0.
  - x0 always reads 0; writes to x0 are ignored.
  - Reads are combinational on Rs1D/Rs2D.
- Decode by opcode. All unlisted controls are 0.
  - lw 0000011: RegWrite, ALUSrc, ResultSrc=01, imm I, ALU add.
  - sw 0100011: MemWrite, ALUSrc, imm S, ALU add.
  - R-type 0110011: RegWrite. ALU from funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
  - I-ALU 0010011: RegWrite, ALUSrc, imm I. Same ALU table, but funct3=000 is always add.
  - beq 1100011: Branch, imm B, ALU sub.
  - jal 1101111: RegWrite, Jump, ResultSrc=10, imm J.
- Unsupported funct3 in R-type/I-ALU: ALUControl=000, IllegalE=1.
- Immediates are sign-extended from bit 31. B and J immediates have bit 0 = 0.
- InstrD=32'h00000000 (fetch bubble): all controls 0, IllegalE=0, treated as NOP.
- Any other unlisted opcode: all controls 0, IllegalE=1.
- FlushE=1 at an edge: all control outputs (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, IllegalE) and RdE/Rs1E/Rs2E load 0. Data fields also load 0.
- FlushE takes priority over the new decode. Async reset takes priority over FlushE.
- There is no stall input. The ID/EX register loads every edge; upstream holds InstrD via the fetch stall.

Optional Feature:
DECODE_WB_BYPASS_EN
- Defined: write-through bypass on reads. If RegWriteW=1, RdW!=0 and RdW==Rs1D (or Rs2D), the corresponding read returns ResultW in the same cycle. A same-cycle writeback/decode pair then yields the new value in RD1E/RD2E.
- Undefined: reads return the stored (pre-write) value. The hazard unit must stall one cycle for this case.

Test Plan:
- Reset: drive rst=0 mid-run with nonzero InstrD -> all *E outputs 0 immediately. After release, reading x1..x31 returns 0.
- addi x5,x0,7 (0x00700293) -> next cycle: RdE=5, ImmExtE=7, RegWriteE=1, ALUSrcE=1, ALUControlE=000, IllegalE=0.
- sw x6,8(x2) (0x00612423) -> MemWriteE=1, RegWriteE=0, ImmExtE=8, Rs1E=2, Rs2E=6. Then beq x1,x2,-4 (0xFE208EE3) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
- Writeback RegWriteW=1, RdW=5, ResultW=0x12345678 in the same cycle as add x7,x5,x0 (0x000283B3):
  - With DECODE_WB_BYPASS_EN: RD1E=0x12345678.
  - Without: RD1E=0; repeating the instruction the next cycle gives 0x12345678.
  - Writing RdW=0 with ResultW=0xFFFFFFFF leaves x0 reading 0.
- FlushE=1 together with InstrD=0x00700293 -> all controls and RdE are 0 next cycle. FlushE=0 the following cycle decodes normally.
- InstrD=0x00000000 -> IllegalE=0, all controls 0. InstrD=0x0000007F -> IllegalE=1, RegWriteE=0, MemWriteE=0.
